// File: rtl/nibble_serial_adder_if.sv
// Operand/result handshake bundle for nibble_serial_adder.
// The slave modport is the adder side; master is the upstream/downstream driver.
interface nibble_serial_adder_if #(
  parameter int unsigned NIBBLES = 4
) ();
  localparam int unsigned W = 4 * NIBBLES;

  logic         valid_i;
  logic         ready_o;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic         carry_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] sum_o;
  logic         carry_o;

  modport slave (
    input  valid_i, a_i, b_i, carry_i, ready_i,
    output ready_o, valid_o, sum_o, carry_o
  );

  modport master (
    output valid_i, a_i, b_i, carry_i, ready_i,
    input  ready_o, valid_o, sum_o, carry_o
  );
endinterface

// File: rtl/nibble_serial_adder.sv
// Serial adder: one 4-bit slice per cycle, LSB nibble first, with a
// valid/ready handshake on both the operand and result sides.
module nibble_serial_adder #(
  parameter int unsigned NIBBLES = 4
) (
  input logic                  clk_i,
  input logic                  reset_i,
  nibble_serial_adder_if.slave bus
);
  localparam int unsigned W = 4 * NIBBLES;

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e       state_q, state_d;
  logic [2:0]   cnt_q, cnt_d;
  logic [W-1:0] a_q, a_d;
  logic [W-1:0] b_q, b_d;
  logic [W-1:0] sum_q, sum_d;
  logic         carry_q, carry_d;
  logic         cout_q, cout_d;
  logic [4:0]   idx;
  logic [4:0]   nib;

  // Bit offset of the nibble being processed this cycle.
  assign idx = {cnt_q, 2'b00};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    nib     = {1'b0, a_q[idx +: 4]} + {1'b0, b_q[idx +: 4]} + {4'b0000, carry_q};
    unique case (state_q)
      StIdle: begin
        if (bus.valid_i) begin
          a_d     = bus.a_i;
          b_d     = bus.b_i;
          carry_d = bus.carry_i;
          cnt_d   = '0;
          state_d = StCalc;
        end
      end
      StCalc: begin
        sum_d[idx +: 4] = nib[3:0];
        carry_d         = nib[4];
        cnt_d           = cnt_q + 3'd1;
        if (cnt_q == 3'(NIBBLES - 1)) begin
          cout_d  = nib[4];
          state_d = StDone;
        end
      end
      StDone: begin
        if (bus.ready_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.ready_o = (state_q == StIdle);
  assign bus.valid_o = (state_q == StDone);
  assign bus.sum_o   = sum_q;
  assign bus.carry_o = cout_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder: directed cases plus random
// operands checked against a plain-arithmetic model.
module tb_nibble_serial_adder;
  localparam int unsigned NIBBLES = 4;
  localparam int unsigned W = 4 * NIBBLES;
  localparam int TIMEOUT = 50;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   cyc;

  nibble_serial_adder_if #(.NIBBLES(NIBBLES)) bus ();

  nibble_serial_adder #(.NIBBLES(NIBBLES)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Advance one edge; inputs change and outputs are sampled 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: full-width addition with one extra bit for the carry.
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic c);
    return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
  endfunction

  // Present operands for one accepting edge, then scramble the inputs.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                      output int acc_cyc);
    int n;
    n = 0;
    while (!bus.ready_o && n < TIMEOUT) begin
      step();
      n++;
    end
    bus.a_i     = a;
    bus.b_i     = b;
    bus.carry_i = c;
    bus.valid_i = 1'b1;
    acc_cyc     = cyc;
    step();
    bus.valid_i = 1'b0;
    bus.a_i     = W'($urandom);
    bus.b_i     = W'($urandom);
    bus.carry_i = 1'($urandom);
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!bus.valid_o && lat < TIMEOUT) begin
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.a_i     = '0;
    bus.b_i     = '0;
    bus.carry_i = 1'b0;
    step();
    step();
    reset = 1'b0;
    total++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.sum_o !== '0 ||
        bus.carry_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: ready=%b valid=%b sum=%h carry=%b, want 1 0 0000 0",
               bus.ready_o, bus.valid_o, bus.sum_o, bus.carry_o);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] av[3];
    logic [W-1:0] bv[3];
    logic         cv[3];
    logic [W:0]   exp;
    int           lat;
    int           t;
    av = '{16'h0000, 16'h000F, 16'hFFFF};
    bv = '{16'h0000, 16'h0001, 16'h0000};
    cv = '{1'b0, 1'b0, 1'b1};
    bus.ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp = model(av[i], bv[i], cv[i]);
      send(av[i], bv[i], cv[i], t);
      wait_valid(lat);
      total++;
      if (lat !== NIBBLES) begin
        bad++;
        $display("FAIL directed_latency[%0d]: got %0d cycles, want %0d", i, lat, NIBBLES);
      end
      total++;
      if ({bus.carry_o, bus.sum_o} !== exp) begin
        bad++;
        $display("FAIL directed_sum[%0d]: got carry=%b sum=%h, want carry=%b sum=%h",
                 i, bus.carry_o, bus.sum_o, exp[W], exp[W-1:0]);
      end
      bus.ready_i = 1'b1;
      step();
      bus.ready_i = 1'b0;
      total++;
      if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0) begin
        bad++;
        $display("FAIL directed_release[%0d]: ready=%b valid=%b, want 1 0",
                 i, bus.ready_o, bus.valid_o);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    int t;
    bus.ready_i = 1'b0;
    send(16'h1234, 16'h4321, 1'b0, t);
    wait_valid(lat);
    for (int i = 0; i < 5; i++) begin
      bus.valid_i = i[0];
      bus.a_i     = W'($urandom);
      bus.b_i     = W'($urandom);
      step();
      total++;
      if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0 || bus.sum_o !== 16'h5555 ||
          bus.carry_o !== 1'b0) begin
        bad++;
        $display("FAIL hold[%0d]: valid=%b ready=%b sum=%h carry=%b, want 1 0 5555 0",
                 i, bus.valid_o, bus.ready_o, bus.sum_o, bus.carry_o);
      end
    end
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b1;
    step();
    bus.ready_i = 1'b0;
    step();
    total++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.sum_o !== 16'h5555) begin
      bad++;
      $display("FAIL hold_release: ready=%b valid=%b sum=%h, want 1 0 5555",
               bus.ready_o, bus.valid_o, bus.sum_o);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    int t1;
    int t2;
    bus.ready_i = 1'b1;
    send(16'h7777, 16'h7777, 1'b0, t1);
    wait_valid(lat);
    total++;
    if ({bus.carry_o, bus.sum_o} !== {1'b0, 16'hEEEE}) begin
      bad++;
      $display("FAIL b2b_first: got carry=%b sum=%h, want 0 eeee", bus.carry_o, bus.sum_o);
    end
    step();
    send(16'h8000, 16'h8000, 1'b0, t2);
    wait_valid(lat);
    total++;
    if ({bus.carry_o, bus.sum_o} !== {1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL b2b_second: got carry=%b sum=%h, want 1 0000", bus.carry_o, bus.sum_o);
    end
    total++;
    if (t2 - t1 !== NIBBLES + 2) begin
      bad++;
      $display("FAIL b2b_interval: got %0d cycles, want %0d", t2 - t1, NIBBLES + 2);
    end
    step();
    bus.ready_i = 1'b0;
  endtask

  task automatic test_reset_mid_calc();
    int t;
    int seen;
    bus.ready_i = 1'b1;
    send(16'hABCD, 16'h1111, 1'b1, t);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    total++;
    if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.sum_o !== 16'h0000 ||
        bus.carry_o !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset: ready=%b valid=%b sum=%h carry=%b, want 1 0 0000 0",
               bus.ready_o, bus.valid_o, bus.sum_o, bus.carry_o);
    end
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (bus.valid_o === 1'b1) seen++;
    end
    total++;
    if (seen !== 0) begin
      bad++;
      $display("FAIL mid_reset_no_result: got %0d valid cycles, want 0", seen);
    end
    // Reset and valid together must not start an operation.
    bus.a_i     = 16'h0F0F;
    bus.b_i     = 16'h0101;
    bus.valid_i = 1'b1;
    reset       = 1'b1;
    step();
    reset       = 1'b0;
    bus.valid_i = 1'b0;
    step();
    total++;
    if (bus.ready_o !== 1'b1 || bus.sum_o !== 16'h0000) begin
      bad++;
      $display("FAIL reset_with_valid: ready=%b sum=%h, want 1 0000", bus.ready_o, bus.sum_o);
    end
    bus.ready_i = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         c;
    logic [W:0]   exp;
    int           lat;
    int           t;
    int           stall;
    for (int i = 0; i < 30; i++) begin
      a   = W'($urandom);
      b   = W'($urandom);
      c   = 1'($urandom);
      if (i == 0) begin
        a = '1;
        b = '1;
        c = 1'b1;
      end
      exp = model(a, b, c);
      send(a, b, c, t);
      lat = 0;
      while (!bus.valid_o && lat < TIMEOUT) begin
        bus.valid_i = 1'($urandom);
        bus.ready_i = 1'($urandom);
        step();
        lat++;
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b0;
      total++;
      if (lat !== NIBBLES || {bus.carry_o, bus.sum_o} !== exp) begin
        bad++;
        $display("FAIL random[%0d]: a=%h b=%h c=%b got lat=%0d carry=%b sum=%h, want lat=%0d carry=%b sum=%h",
                 i, a, b, c, lat, bus.carry_o, bus.sum_o, NIBBLES, exp[W], exp[W-1:0]);
      end
      stall = $urandom_range(0, 3);
      for (int s = 0; s < stall; s++) begin
        bus.valid_i = 1'($urandom);
        step();
        total++;
        if (bus.valid_o !== 1'b1 || {bus.carry_o, bus.sum_o} !== exp) begin
          bad++;
          $display("FAIL random_stall[%0d]: valid=%b carry=%b sum=%h, want 1 %b %h",
                   i, bus.valid_o, bus.carry_o, bus.sum_o, exp[W], exp[W-1:0]);
        end
      end
      bus.valid_i = 1'b0;
      bus.ready_i = 1'b1;
      step();
      bus.ready_i = 1'b0;
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    test_reset();
    test_directed();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_calc();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
- REQ-001: Parameter NIBBLES, default 4, SHALL set the number of 4-bit slices; operand width W = 4*NIBBLES; legal range 2..8.
- REQ-002: clk_i  input  1  single clock; all state SHALL update on its rising edge.
- REQ-003: reset_i  input  1  synchronous, active-high reset.
- REQ-004: valid_i  input  1  upstream operands valid.
- REQ-005: ready_o  output  1  block can accept operands.
- REQ-006: a_i  input  W  operand A, unsigned.
- REQ-007: b_i  input  W  operand B, unsigned.
- REQ-008: carry_i  input  1  carry-in for the least-significant nibble.
- REQ-009: valid_o  output  1  result valid.
- REQ-010: ready_i  input  1  downstream accepts result.
- REQ-011: sum_o  output  W  registered sum, A+B+carry_i mod 2^W.
- REQ-012: carry_o  output  1  registered carry out of the most-significant nibble.

Function
- REQ-013: The FSM SHALL have exactly three states: IDLE, CALC and DONE.
- REQ-014: ready_o SHALL be 1 only in IDLE, and valid_o SHALL be 1 only in DONE; both are decoded from state only, with no input-to-output combinational path.
- REQ-015: In IDLE, valid_i=1 at an edge SHALL capture a_i, b_i and carry_i into internal registers, clear the nibble counter to 0, and enter CALC.
- REQ-016: a_i, b_i and carry_i need not be held stable after the accepting edge.
- REQ-017: Each CALC cycle SHALL compute one nibble, k = counter: {c,s} = A[4k+3:4k] + B[4k+3:4k] + carry_reg (5-bit result).
- REQ-018: The block SHALL write s into sum_o[4k+3:4k], set carry_reg to c, and increment the counter.
- REQ-019: carry_reg SHALL be loaded from carry_i at acceptance; the carry chain proceeds from the LSB nibble to the MSB nibble.
- REQ-020: After the nibble with k = NIBBLES-1, the FSM SHALL enter DONE and carry_o SHALL take the final c.
- REQ-021: Latency: if operands are accepted at edge T, valid_o SHALL rise after edge T+NIBBLES (NIBBLES CALC cycles).
- REQ-022: In DONE, sum_o, carry_o and valid_o SHALL hold stable while ready_i=0, for any duration.
- REQ-023: In DONE, ready_i=1 at an edge SHALL complete the transfer and return to IDLE; next acceptance is possible no earlier than the following edge.
- REQ-024: Minimum issue interval SHALL be NIBBLES+2 cycles.
- REQ-025: valid_i SHALL be ignored in CALC and DONE; no operand capture or state change may result.
- REQ-026: ready_i SHALL be ignored outside DONE.
- REQ-027: sum_o and carry_o are meaningful only when valid_o=1; outside CALC they SHALL retain their last value.
- REQ-028: Overflow SHALL wrap mod 2^W, with the overflow bit reported on carry_o.

Reset
- REQ-029: On reset_i=1 at an edge, the block SHALL set state to IDLE, counter to 0, carry_reg to 0, sum_o to 0 and carry_o to 0; consequently ready_o=1 and valid_o=0 after that edge.
- REQ-030: Reset SHALL take priority over every handshake; reset mid-CALC or mid-DONE SHALL abort the operation with no valid_o pulse.
- REQ-031: reset_i and valid_i both high at the same edge SHALL NOT capture operands.

Verification
- REQ-032: Reset, then a_i=0x0000, b_i=0x0000, carry_i=0 -> valid_o after 4 CALC cycles, sum_o=0x0000, carry_o=0.
- REQ-033: a_i=0x000F, b_i=0x0001, carry_i=0 -> sum_o=0x0010, carry_o=0 (inter-nibble carry).
- REQ-034: a_i=0xFFFF, b_i=0x0000, carry_i=1 -> sum_o=0x0000, carry_o=1 (full-chain ripple).
- REQ-035: a_i=0x1234, b_i=0x4321, ready_i=0 for 5 cycles, valid_i pulsed meanwhile -> valid_o held, sum_o=0x5555 stable, ready_o=0, no new capture.
- REQ-036: Back-to-back with ready_i=1: 0x7777+0x7777+0 -> 0xEEEE, carry_o=0; then 0x8000+0x8000+0 -> 0x0000, carry_o=1; issue interval = 6 cycles.
- REQ-037: reset_i=1 for one cycle during the 2nd CALC cycle -> after that edge ready_o=1, valid_o=0, sum_o=0x0000, and no result is ever presented.
